data_bus_if: RTL and testbench

//  Data-side bus master between the MEM stage and the external data memory bus.

---
 rtl/data_bus_if.sv | 170 +++++++++++++++++
 tb/tb_data_bus_if.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/data_bus_if.sv
// Data-side bus master: turns a single-cycle MEM stage access into a registered
// req/ack bus transfer, stalls the pipeline until done and returns read data.
module data_bus_if #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_rdata_o,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY       = 2'd1,
    WAIT_STALL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 32'd1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic             drop_r;
  logic [31:0]      rd_buf_r;
  logic             err_r;
  logic             issue_s;
  logic             timeout_s;
  logic             done_s;
  logic             drop_s;

  // A timeout completes the transfer exactly like an ack carrying zero data.
  always_comb begin
    issue_s   = (state_r == IDLE) && mem_ce_i && !flush_i;
    timeout_s = (state_r == BUSY) && !bus_ack_i && (cnt_r == CNT_LAST);
    done_s    = (state_r == BUSY) && (bus_ack_i || timeout_s);
    drop_s    = drop_r || flush_i;
  end

  // Next-state and combinational MEM-side outputs.
  always_comb begin
    state_nxt_s = state_r;
    stallreq_o  = 1'b0;
    mem_rdata_o = 32'h0000_0000;
    case (state_r)
      IDLE: begin
        stallreq_o = issue_s;
        if (issue_s) begin
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        stallreq_o = !done_s;
        if (done_s && bus_ack_i && !bus_we_o && !drop_s) begin
          mem_rdata_o = bus_rdata_i;
        end else begin
          mem_rdata_o = 32'h0000_0000;
        end
        if (!done_s) begin
          state_nxt_s = BUSY;
        end else if (drop_s) begin
          state_nxt_s = IDLE;
        end else if (stall_i) begin
          state_nxt_s = WAIT_STALL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT_STALL: begin
        mem_rdata_o = rd_buf_r;
        if (!stall_i || flush_i) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_STALL;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Bus-side registers, timeout counter, drop flag and read buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 32'h0000_0000;
      bus_sel_o   <= 4'h0;
      bus_wdata_o <= 32'h0000_0000;
      cnt_r       <= '0;
      drop_r      <= 1'b0;
      rd_buf_r    <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (issue_s) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= mem_we_i;
            bus_addr_o  <= mem_addr_i;
            bus_sel_o   <= mem_sel_i;
            bus_wdata_o <= mem_data_i;
            cnt_r       <= '0;
            drop_r      <= 1'b0;
          end
        end
        BUSY: begin
          if (done_s) begin
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= 32'h0000_0000;
            bus_sel_o   <= 4'h0;
            bus_wdata_o <= 32'h0000_0000;
            cnt_r       <= '0;
            drop_r      <= 1'b0;
            rd_buf_r    <= (bus_ack_i && !bus_we_o && !drop_s) ? bus_rdata_i : 32'h0000_0000;
          end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
            drop_r <= drop_s;
          end
        end
        WAIT_STALL: begin
          drop_r <= 1'b0;
        end
        default: begin
          bus_req_o <= 1'b0;
          drop_r    <= 1'b0;
        end
      endcase
    end
  end

  // Timeout error pulse, one cycle after the forced completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= timeout_s;
    end
  end

  assign bus_err_o = err_r;

endmodule

// File: tb/tb_data_bus_if.sv
// Randomized self-checking bench for data_bus_if; the bench plays the bus slave
// and predicts every cycle of a transfer from its timing parameters.
module tb_data_bus_if;

  localparam int TIMEOUT = 4;

  logic        clk;
  logic        rst;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_rdata_o;
  logic        stall_i;
  logic        flush_i;
  logic        stallreq_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic        bus_err_o;

  int check_cnt = 0;
  int err_cnt   = 0;

  data_bus_if #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_sel_i(mem_sel_i), .mem_data_i(mem_data_i), .mem_rdata_o(mem_rdata_o),
    .stall_i(stall_i), .flush_i(flush_i), .stallreq_o(stallreq_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i),
    .bus_rdata_i(bus_rdata_i), .bus_err_o(bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bus_idle(input string tag);
    check_eq({tag, "_req"},   32'(bus_req_o),  32'd0);
    check_eq({tag, "_we"},    32'(bus_we_o),   32'd0);
    check_eq({tag, "_addr"},  bus_addr_o,      32'd0);
    check_eq({tag, "_sel"},   32'(bus_sel_o),  32'd0);
    check_eq({tag, "_wdata"}, bus_wdata_o,     32'd0);
  endtask

  // One MEM access: d = BUSY cycles without ack before the ack, flush_at = BUSY
  // cycle carrying flush (0 = none), stall_after = cycles stall_i holds after completion.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int d, input int flush_at, input int stall_after);
    int          n;
    int          w;
    bit          acked;
    bit          dropped;
    logic [31:0] buf_exp;
    logic [31:0] rd_exp;
    acked   = (d + 1 <= TIMEOUT);
    n       = acked ? d + 1 : TIMEOUT;
    dropped = (flush_at >= 1) && (flush_at <= n);
    buf_exp = (acked && !we) ? rdata : 32'd0;
    w       = dropped ? 0 : stall_after;

    step();
    mem_ce_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_sel_i = sel; mem_data_i = wdata;
    flush_i = 1'b0; stall_i = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = $urandom;
    #3;
    check_eq("issue_stallreq", 32'(stallreq_o), 32'd1);
    check_eq("issue_req", 32'(bus_req_o), 32'd0);
    check_eq("issue_rdata", mem_rdata_o, 32'd0);
    check_eq("issue_err", 32'(bus_err_o), 32'd0);

    for (int k = 1; k <= n; k++) begin
      step();
      mem_addr_i  = $urandom;
      mem_data_i  = $urandom;
      flush_i     = (k == flush_at);
      bus_ack_i   = acked && (k == n);
      bus_rdata_i = (acked && k == n) ? rdata : $urandom;
      stall_i     = (k == n) ? (stall_after > 0) : 1'b1;
      #3;
      rd_exp = (k == n && acked && !we && !dropped) ? rdata : 32'd0;
      check_eq("busy_req", 32'(bus_req_o), 32'd1);
      check_eq("busy_we", 32'(bus_we_o), 32'(we));
      check_eq("busy_addr", bus_addr_o, addr);
      check_eq("busy_sel", 32'(bus_sel_o), 32'(sel));
      check_eq("busy_wdata", bus_wdata_o, wdata);
      check_eq("busy_stallreq", 32'(stallreq_o), (k == n) ? 32'd0 : 32'd1);
      check_eq("busy_rdata", mem_rdata_o, rd_exp);
      check_eq("busy_err", 32'(bus_err_o), 32'd0);
    end

    for (int j = 1; j <= w; j++) begin
      step();
      flush_i = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = $urandom;
      stall_i = (j < w);
      #3;
      check_eq("wait_stallreq", 32'(stallreq_o), 32'd0);
      check_eq("wait_req", 32'(bus_req_o), 32'd0);
      check_eq("wait_rdata", mem_rdata_o, buf_exp);
      check_eq("wait_err", 32'(bus_err_o), (j == 1 && !acked) ? 32'd1 : 32'd0);
    end

    step();
    mem_ce_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
    bus_ack_i = 1'b1; bus_rdata_i = $urandom;
    #3;
    check_bus_idle("after");
    check_eq("after_stallreq", 32'(stallreq_o), 32'd0);
    check_eq("after_rdata", mem_rdata_o, 32'd0);
    check_eq("after_err", 32'(bus_err_o), (w == 0 && !acked) ? 32'd1 : 32'd0);
    bus_ack_i = 1'b0;
  endtask

  initial begin
    logic [3:0]  sel_tab [7];
    logic        we;
    logic [3:0]  sel;
    sel_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

    rst = 1'b0; mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = 32'd0; mem_sel_i = 4'd0;
    mem_data_i = 32'd0; stall_i = 1'b0; flush_i = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = 32'd0;
    #2;
    check_bus_idle("reset");
    check_eq("reset_stallreq", 32'(stallreq_o), 32'd0);
    check_eq("reset_rdata", mem_rdata_o, 32'd0);
    check_eq("reset_err", 32'(bus_err_o), 32'd0);
    step();
    step();
    rst = 1'b1;

    run_txn(1'b0, 32'h0000_0100, 4'b1111, 32'd0, 32'hDEAD_BEEF, 3, 0, 0);
    run_txn(1'b1, 32'h0000_0103, 4'b0001, 32'h5A5A_5A5A, 32'd0, 0, 0, 0);
    run_txn(1'b0, 32'h0000_0200, 4'b1111, 32'd0, 32'h1234_5678, 1, 0, 3);
    run_txn(1'b0, 32'h0000_0300, 4'b1111, 32'd0, 32'hCAFE_F00D, 10, 0, 0);
    run_txn(1'b0, 32'h0000_0304, 4'b1111, 32'd0, 32'hCAFE_F00D, 10, 0, 2);
    run_txn(1'b0, 32'h0000_0400, 4'b1111, 32'd0, 32'hA5A5_0F0F, 3, 2, 2);

    // A flush in the request cycle must suppress the access entirely.
    step();
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h0000_0500; flush_i = 1'b1;
    #3;
    check_eq("flushed_issue_stallreq", 32'(stallreq_o), 32'd0);
    step();
    mem_ce_i = 1'b0; flush_i = 1'b0;
    #3;
    check_eq("flushed_issue_req", 32'(bus_req_o), 32'd0);

    for (int t = 0; t < 60; t++) begin
      we  = 1'($urandom_range(0, 1));
      sel = we ? sel_tab[$urandom_range(0, 6)] : 4'b1111;
      run_txn(we, $urandom, sel, $urandom, $urandom, $urandom_range(0, 5),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, $urandom_range(0, 2));
    end

    // Reset asserted in the middle of a transfer.
    step();
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h0000_0600; mem_sel_i = 4'b1111;
    mem_data_i = 32'h1111_2222;
    step();
    #3;
    check_eq("midrst_pre_req", 32'(bus_req_o), 32'd1);
    #2;
    rst = 1'b0; mem_ce_i = 1'b0;
    #1;
    check_bus_idle("midrst");
    check_eq("midrst_stallreq", 32'(stallreq_o), 32'd0);
    step();
    rst = 1'b1;
    run_txn(1'b0, 32'h0000_0700, 4'b1111, 32'd0, 32'h0BAD_CAFE, 2, 0, 0);

    $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
    $finish;
  end

endmodule
